// File: rtl/pred_pkg.sv
// rtl/pred_pkg.sv - shared predictor types, defaults and saturating arithmetic helpers
package pred_pkg;

    localparam int DEF_ADDR_W = 3;
    localparam int DEF_CTR_W  = 2;
    localparam int DEF_STAT_W = 16;

    typedef enum logic {
        INIT,
        RUN
    } pred_state_t;

    // Helpers work on a 32-bit carrier; callers size the result back to their width w.
    function automatic logic [31:0] sat_inc(input logic [31:0] v, input int w);
        logic [31:0] max;
        max = (w >= 32) ? 32'hffff_ffff : ((32'd1 << w) - 32'd1);
        return (v >= max) ? max : v + 32'd1;
    endfunction

    function automatic logic [31:0] sat_dec(input logic [31:0] v);
        return (v == 32'd0) ? 32'd0 : v - 32'd1;
    endfunction

endpackage

// File: rtl/sat_ctr_upd.sv
// rtl/sat_ctr_upd.sv - combinational CTR_W-bit saturating counter next-value
module sat_ctr_upd
    import pred_pkg::*;
#(
    parameter int CTR_W = DEF_CTR_W
) (
    input  logic [CTR_W-1:0] cur,
    input  logic             taken,
    output logic [CTR_W-1:0] nxt
);

    always_comb begin
        nxt = cur;
        if (taken) begin
            nxt = CTR_W'(sat_inc(32'(cur), CTR_W));
        end else begin
            nxt = CTR_W'(sat_dec(32'(cur)));
        end
    end

endmodule

// File: rtl/nbit_pred_table.sv
// rtl/nbit_pred_table.sv - direct-mapped table of saturating branch counters
// Optional statistics counters enabled by defining PRED_STATS_EN.
module nbit_pred_table
    import pred_pkg::*;
#(
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int CTR_W    = DEF_CTR_W,
    parameter int INIT_VAL = (1 << (CTR_W - 1)) - 1,
    parameter int STAT_W   = DEF_STAT_W
) (
    input  logic              clk,
    input  logic              rst,
    output logic              ready,
    input  logic              lk_valid,
    input  logic [ADDR_W-1:0] lk_addr,
    output logic              pred_valid,
    output logic              pred_taken,
    output logic [CTR_W-1:0]  pred_ctr,
    input  logic              up_valid,
    input  logic [ADDR_W-1:0] up_addr,
    input  logic              up_taken,
    input  logic              up_pred,
    output logic              miss
`ifdef PRED_STATS_EN
    ,
    output logic [STAT_W-1:0] miss_cnt,
    output logic [STAT_W-1:0] upd_cnt
`endif
);

    localparam int DEPTH = 1 << ADDR_W;

    if (CTR_W < 1 || CTR_W > 32 || STAT_W < 1 || STAT_W > 32) begin : g_bad_param
        $error("nbit_pred_table: CTR_W and STAT_W must lie in 1..32");
    end

    pred_state_t       state;
    logic [ADDR_W-1:0] ptr;
    logic [CTR_W-1:0]  tbl [DEPTH];
    logic [CTR_W-1:0]  upd_nxt;
    logic [CTR_W-1:0]  lk_ctr;
    logic              miss_nxt;

    sat_ctr_upd #(.CTR_W(CTR_W)) u_sat (
        .cur   (tbl[up_addr]),
        .taken (up_taken),
        .nxt   (upd_nxt)
    );

    // Write-first: a lookup colliding with an update sees the trained value.
    assign lk_ctr   = (up_valid && (up_addr == lk_addr)) ? upd_nxt : tbl[lk_addr];
    assign miss_nxt = up_valid & ready & (up_taken != up_pred);

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= INIT;
            ptr        <= '0;
            ready      <= 1'b0;
            pred_valid <= 1'b0;
            pred_taken <= 1'b0;
            pred_ctr   <= '0;
            miss       <= 1'b0;
        end else begin
            case (state)
                INIT: begin
                    tbl[ptr]   <= CTR_W'(INIT_VAL);
                    ptr        <= ptr + 1'b1;
                    pred_valid <= 1'b0;
                    miss       <= 1'b0;
                    if (&ptr) begin
                        state <= RUN;
                        ready <= 1'b1;
                    end
                end
                RUN: begin
                    if (up_valid) begin
                        tbl[up_addr] <= upd_nxt;
                    end
                    pred_valid <= lk_valid;
                    pred_ctr   <= lk_ctr;
                    pred_taken <= lk_ctr[CTR_W-1];
                    miss       <= miss_nxt;
                end
                default: state <= INIT;
            endcase
        end
    end

`ifdef PRED_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            upd_cnt  <= '0;
            miss_cnt <= '0;
        end else if (state == RUN && up_valid) begin
            upd_cnt <= STAT_W'(sat_inc(32'(upd_cnt), STAT_W));
            if (miss_nxt) begin
                miss_cnt <= STAT_W'(sat_inc(32'(miss_cnt), STAT_W));
            end
        end
    end
`endif

endmodule
